// File: rtl/gpio_reg_arb.sv
// Two-master round-robin arbiter in front of a single GPIO register bus,
// with a per-transfer wait timeout that answers the master with all-ones.
module gpio_reg_arb #(
  parameter logic [7:0] TMO_CYC = 8'd255
) (
  input  logic        mclk,
  input  logic        h_reset_n,

  input  logic        m0_reg_cs,
  input  logic        m0_reg_wr,
  input  logic [3:0]  m0_reg_addr,
  input  logic [31:0] m0_reg_wdata,
  input  logic [3:0]  m0_reg_be,
  output logic [31:0] m0_reg_rdata,
  output logic        m0_reg_ack,

  input  logic        m1_reg_cs,
  input  logic        m1_reg_wr,
  input  logic [3:0]  m1_reg_addr,
  input  logic [31:0] m1_reg_wdata,
  input  logic [3:0]  m1_reg_be,
  output logic [31:0] m1_reg_rdata,
  output logic        m1_reg_ack,

  output logic        s_reg_cs,
  output logic        s_reg_wr,
  output logic [3:0]  s_reg_addr,
  output logic [31:0] s_reg_wdata,
  output logic [3:0]  s_reg_be,
  input  logic [31:0] s_reg_rdata,
  input  logic        s_reg_ack,

  output logic        tmo_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        last_gnt, last_gnt_nxt;
  logic [7:0]  wait_cnt, wait_cnt_nxt;

  logic        cur;
  logic        sel_cs;
  logic        timeout;
  logic        resp_ack;
  logic [31:0] resp_rdata;

  always_ff @(posedge mclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    wait_cnt_nxt = wait_cnt;
    cur          = 1'b0;
    sel_cs       = 1'b0;
    timeout      = 1'b0;
    resp_ack     = 1'b0;
    resp_rdata   = '0;
    s_reg_cs     = 1'b0;
    s_reg_wr     = 1'b0;
    s_reg_addr   = '0;
    s_reg_wdata  = '0;
    s_reg_be     = '0;
    tmo_err      = 1'b0;
    m0_reg_ack   = 1'b0;
    m0_reg_rdata = '0;
    m1_reg_ack   = 1'b0;
    m1_reg_rdata = '0;

    case (state)
      IDLE: begin
        wait_cnt_nxt = '0;
        if (m0_reg_cs && m1_reg_cs)
          state_nxt = last_gnt ? GNT0 : GNT1;
        else if (m0_reg_cs)
          state_nxt = GNT0;
        else if (m1_reg_cs)
          state_nxt = GNT1;
      end

      GNT0, GNT1: begin
        cur         = (state == GNT1);
        sel_cs      = cur ? m1_reg_cs    : m0_reg_cs;
        s_reg_wr    = cur ? m1_reg_wr    : m0_reg_wr;
        s_reg_addr  = cur ? m1_reg_addr  : m0_reg_addr;
        s_reg_wdata = cur ? m1_reg_wdata : m0_reg_wdata;
        s_reg_be    = cur ? m1_reg_be    : m0_reg_be;

        // A real ack in the limit cycle wins over the timeout.
        timeout    = sel_cs && !s_reg_ack && (wait_cnt == TMO_CYC);
        s_reg_cs   = sel_cs && !timeout;
        resp_ack   = s_reg_ack || timeout;
        resp_rdata = timeout ? '1 : s_reg_rdata;
        tmo_err    = timeout;

        if (resp_ack) begin
          state_nxt    = IDLE;
          last_gnt_nxt = cur;
        end else if (!sel_cs) begin
          state_nxt = IDLE;
        end else if (wait_cnt != TMO_CYC) begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end

        if (cur) begin
          m1_reg_ack   = resp_ack;
          m1_reg_rdata = resp_rdata;
        end else begin
          m0_reg_ack   = resp_ack;
          m0_reg_rdata = resp_rdata;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gpio_reg_arb.sv
// Directed bench for gpio_reg_arb: write, round-robin ties, read mux,
// timeout, ack-at-limit, abort, and asynchronous reset mid-transfer.
module tb_gpio_reg_arb;

  logic        mclk;
  logic        h_reset_n;
  logic        m0_reg_cs, m0_reg_wr, m1_reg_cs, m1_reg_wr;
  logic [3:0]  m0_reg_addr, m0_reg_be, m1_reg_addr, m1_reg_be;
  logic [31:0] m0_reg_wdata, m1_reg_wdata, m0_reg_rdata, m1_reg_rdata;
  logic        m0_reg_ack, m1_reg_ack;
  logic        s_reg_cs, s_reg_wr, s_reg_ack, tmo_err;
  logic [3:0]  s_reg_addr, s_reg_be;
  logic [31:0] s_reg_wdata, s_reg_rdata;

  int checks   = 0;
  int failures = 0;

  gpio_reg_arb #(.TMO_CYC(8'd4)) dut (
    .mclk         (mclk),
    .h_reset_n    (h_reset_n),
    .m0_reg_cs    (m0_reg_cs),
    .m0_reg_wr    (m0_reg_wr),
    .m0_reg_addr  (m0_reg_addr),
    .m0_reg_wdata (m0_reg_wdata),
    .m0_reg_be    (m0_reg_be),
    .m0_reg_rdata (m0_reg_rdata),
    .m0_reg_ack   (m0_reg_ack),
    .m1_reg_cs    (m1_reg_cs),
    .m1_reg_wr    (m1_reg_wr),
    .m1_reg_addr  (m1_reg_addr),
    .m1_reg_wdata (m1_reg_wdata),
    .m1_reg_be    (m1_reg_be),
    .m1_reg_rdata (m1_reg_rdata),
    .m1_reg_ack   (m1_reg_ack),
    .s_reg_cs     (s_reg_cs),
    .s_reg_wr     (s_reg_wr),
    .s_reg_addr   (s_reg_addr),
    .s_reg_wdata  (s_reg_wdata),
    .s_reg_be     (s_reg_be),
    .s_reg_rdata  (s_reg_rdata),
    .s_reg_ack    (s_reg_ack),
    .tmo_err      (tmo_err)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge mclk);
    #1;
  endtask

  task automatic reset_pulse;
    h_reset_n = 1'b0;
    step();
    h_reset_n = 1'b1;
  endtask

  initial begin
    h_reset_n    = 1'b0;
    m0_reg_cs    = 1'b0; m0_reg_wr = 1'b0; m0_reg_addr = '0; m0_reg_wdata = '0; m0_reg_be = '0;
    m1_reg_cs    = 1'b0; m1_reg_wr = 1'b0; m1_reg_addr = '0; m1_reg_wdata = '0; m1_reg_be = '0;
    s_reg_ack    = 1'b0; s_reg_rdata = '0;
    repeat (3) @(posedge mclk);
    #1;
    m0_reg_cs = 1'b1;
    #1;
    check("rst_s_cs", {31'd0, s_reg_cs}, 32'd0);
    check("rst_m0_ack", {31'd0, m0_reg_ack}, 32'd0);
    check("rst_m0_rdata", m0_reg_rdata, 32'd0);
    check("rst_tmo", {31'd0, tmo_err}, 32'd0);
    m0_reg_cs = 1'b0;
    h_reset_n = 1'b1;

    // single write from m0, acked on second cs cycle
    step();
    m0_reg_cs = 1'b1; m0_reg_wr = 1'b1; m0_reg_addr = 4'h2; m0_reg_wdata = 32'h0000_00A5; m0_reg_be = 4'hF;
    #3;
    check("wr_idle_cs", {31'd0, s_reg_cs}, 32'd0);
    step(); #3;
    check("wr_cs", {31'd0, s_reg_cs}, 32'd1);
    check("wr_wr", {31'd0, s_reg_wr}, 32'd1);
    check("wr_addr", {28'd0, s_reg_addr}, 32'd2);
    check("wr_wdata", s_reg_wdata, 32'h0000_00A5);
    check("wr_be", {28'd0, s_reg_be}, 32'hF);
    check("wr_ack_early", {31'd0, m0_reg_ack}, 32'd0);
    step();
    s_reg_ack = 1'b1;
    #3;
    check("wr_m0_ack", {31'd0, m0_reg_ack}, 32'd1);
    check("wr_m1_ack", {31'd0, m1_reg_ack}, 32'd0);
    step();
    s_reg_ack = 1'b0; m0_reg_cs = 1'b0; m0_reg_wr = 1'b0;
    #3;
    check("wr_ack_done", {31'd0, m0_reg_ack}, 32'd0);
    check("wr_idle_addr", {28'd0, s_reg_addr}, 32'd0);

    // ties after reset: m0, m1, m0
    reset_pulse();
    step();
    m0_reg_cs = 1'b1; m0_reg_addr = 4'h1;
    m1_reg_cs = 1'b1; m1_reg_addr = 4'h8;
    #3;
    check("tie_idle_cs", {31'd0, s_reg_cs}, 32'd0);
    step(); #3;
    check("tie1_addr", {28'd0, s_reg_addr}, 32'h1);
    s_reg_ack = 1'b1; s_reg_rdata = 32'h0000_0011;
    #1;
    check("tie1_m0_ack", {31'd0, m0_reg_ack}, 32'd1);
    check("tie1_m0_rdata", m0_reg_rdata, 32'h0000_0011);
    check("tie1_m1_ack", {31'd0, m1_reg_ack}, 32'd0);
    check("tie1_m1_rdata", m1_reg_rdata, 32'd0);
    step();
    s_reg_ack = 1'b0;
    #3;
    check("tie_gap_cs", {31'd0, s_reg_cs}, 32'd0);
    step(); #3;
    check("tie2_addr", {28'd0, s_reg_addr}, 32'h8);
    s_reg_ack = 1'b1; s_reg_rdata = 32'h1234_5678;
    #1;
    check("rd_m1_rdata", m1_reg_rdata, 32'h1234_5678);
    check("rd_m0_rdata", m0_reg_rdata, 32'd0);
    check("rd_m1_ack", {31'd0, m1_reg_ack}, 32'd1);
    check("rd_m0_ack", {31'd0, m0_reg_ack}, 32'd0);
    step();
    s_reg_ack = 1'b0;
    #3;
    step(); #3;
    check("tie3_addr", {28'd0, s_reg_addr}, 32'h1);
    s_reg_ack = 1'b1;
    #1;
    check("tie3_m0_ack", {31'd0, m0_reg_ack}, 32'd1);
    step();
    s_reg_ack = 1'b0; s_reg_rdata = '0; m0_reg_cs = 1'b0; m1_reg_cs = 1'b0;

    // timeout after 4 wait cycles
    m0_reg_cs = 1'b1; m0_reg_addr = 4'h5;
    #3;
    for (int i = 0; i < 4; i++) begin
      step(); #3;
      check("tmo_wait_ack", {31'd0, m0_reg_ack}, 32'd0);
      check("tmo_wait_err", {31'd0, tmo_err}, 32'd0);
    end
    step(); #3;
    check("tmo_ack", {31'd0, m0_reg_ack}, 32'd1);
    check("tmo_rdata", m0_reg_rdata, 32'hFFFF_FFFF);
    check("tmo_err", {31'd0, tmo_err}, 32'd1);
    check("tmo_s_cs", {31'd0, s_reg_cs}, 32'd0);
    check("tmo_m1_ack", {31'd0, m1_reg_ack}, 32'd0);
    step();
    m0_reg_cs = 1'b0;
    #3;
    check("tmo_after_err", {31'd0, tmo_err}, 32'd0);
    check("tmo_after_ack", {31'd0, m0_reg_ack}, 32'd0);

    // ack coinciding with the limit cycle is a normal completion
    step();
    m0_reg_cs = 1'b1;
    #3;
    repeat (4) step();
    step();
    s_reg_ack = 1'b1; s_reg_rdata = 32'hCAFE_F00D;
    #3;
    check("lim_ack", {31'd0, m0_reg_ack}, 32'd1);
    check("lim_rdata", m0_reg_rdata, 32'hCAFE_F00D);
    check("lim_err", {31'd0, tmo_err}, 32'd0);
    step();
    s_reg_ack = 1'b0; s_reg_rdata = '0; m0_reg_cs = 1'b0;

    // abort keeps last_gnt=1, so the following tie still goes to m0
    reset_pulse();
    step();
    m0_reg_cs = 1'b1; m0_reg_wr = 1'b1; m0_reg_addr = 4'h3;
    #3;
    step(); #3;
    check("abt_cs", {31'd0, s_reg_cs}, 32'd1);
    step();
    m0_reg_cs = 1'b0;
    #3;
    check("abt_s_cs", {31'd0, s_reg_cs}, 32'd0);
    check("abt_ack", {31'd0, m0_reg_ack}, 32'd0);
    check("abt_err", {31'd0, tmo_err}, 32'd0);
    step();
    m0_reg_cs = 1'b1; m1_reg_cs = 1'b1; m1_reg_addr = 4'h8;
    #3;
    check("abt_idle_cs", {31'd0, s_reg_cs}, 32'd0);
    step(); #3;
    check("abt_keep_last", {28'd0, s_reg_addr}, 32'h3);
    s_reg_ack = 1'b1;
    #1;
    step();
    s_reg_ack = 1'b0; m0_reg_cs = 1'b0;
    #3;
    step(); #3;
    check("rst_mid_cs_pre", {31'd0, s_reg_cs}, 32'd1);
    check("rst_mid_addr_pre", {28'd0, s_reg_addr}, 32'h8);
    h_reset_n = 1'b0;
    #1;
    check("rst_mid_cs", {31'd0, s_reg_cs}, 32'd0);
    check("rst_mid_ack", {31'd0, m1_reg_ack}, 32'd0);
    check("rst_mid_addr", {28'd0, s_reg_addr}, 32'd0);
    m1_reg_cs = 1'b0;
    s_reg_ack = 1'b1;
    step();
    step();
    h_reset_n = 1'b1;
    step(); #3;
    check("idle_ack_m1", {31'd0, m1_reg_ack}, 32'd0);
    check("idle_ack_m0", {31'd0, m0_reg_ack}, 32'd0);
    check("idle_ack_cs", {31'd0, s_reg_cs}, 32'd0);
    step();
    s_reg_ack = 1'b0;
    #3;
    check("post_rst_cs", {31'd0, s_reg_cs}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
